// File: rtl/sha256_compress_ctrl.sv
// ---------------------------------------------------------------------------
// sha256_compress_ctrl
//   Sequences the SHA-256 compression of one 512-bit message block. Owns the
//   working variables a..h, the 16-word message-schedule window, the round
//   counter and the chaining hash H0..H7. ROUNDS_PER_CYCLE copies of
//   sha256_round are chained so that 1, 2 or 4 rounds retire per clock.
//
//   Ports
//     clk           clock, all state updates on the rising edge
//     rst           synchronous active-high reset
//     blk_valid     block offered by the front end
//     blk_ready     controller idle, block will be accepted this cycle
//     blk_data      512-bit block, blk_data[511:480] = W0
//     blk_first     1 = first block of a message (chain from IV)
//     mode_224      (SHA224_EN only) select SHA-224 IV, sampled with blk_first=1
//     busy          high while rounds or the final add are in progress
//     digest        H0..H7, digest[255:224] = H0
//     digest_valid  one-cycle pulse when digest updates
//
//   Build option: define SHA224_EN to add the mode_224 port and SHA-224 IV.
// ---------------------------------------------------------------------------

module sha256_round (
  input  logic [255:0] state_in,
  input  logic [31:0]  k,
  input  logic [31:0]  w,
  output logic [255:0] state_out
);

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32'd32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 32'd2) ^ rotr(x, 32'd13) ^ rotr(x, 32'd22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 32'd6) ^ rotr(x, 32'd11) ^ rotr(x, 32'd25);
  endfunction

  logic [31:0] a, b, c, d, e, f, g, h, t1, t2;

  // One SHA-256 round: unpack a..h, form T1/T2, repack shifted state.
  always_comb begin
    {a, b, c, d, e, f, g, h} = state_in;
    t1 = h + bsig1(e) + ((e & f) ^ (~e & g)) + k + w;
    t2 = bsig0(a) + ((a & b) ^ (a & c) ^ (b & c));
    state_out = {t1 + t2, a, b, c, d + t1, e, f, g};
  end

endmodule

module sha256_compress_ctrl #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  input  logic         blk_first,
`ifdef SHA224_EN
  input  logic         mode_224,
`endif
  output logic         busy,
  output logic [255:0] digest,
  output logic         digest_valid
);

  localparam int R = ROUNDS_PER_CYCLE;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ROUND = 2'd1;
  localparam logic [1:0] ST_FINAL = 2'd2;

  localparam logic [255:0] IV_256 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

`ifdef SHA224_EN
  localparam logic [255:0] IV_224 = {
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
`endif

  localparam logic [0:63][31:0] K_TAB = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  // Only 1, 2 and 4 divide 64 into whole cycles with a schedule chain of <= 4.
  if (!(R == 1 || R == 2 || R == 4)) begin : g_bad_rpc
    $error("sha256_compress_ctrl: ROUNDS_PER_CYCLE must be 1, 2 or 4");
  end

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32'd32 - n));
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 32'd7) ^ rotr(x, 32'd18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 32'd17) ^ rotr(x, 32'd19) ^ (x >> 10);
  endfunction

  logic [1:0]         state;
  logic [6:0]         cnt;
  logic [15:0][31:0]  win;        // win[0] is the word used by the next round
  logic [15:0][31:0]  win_next;
  logic [255:0]       work;
  logic [255:0]       base;       // chaining value the block started from
  logic [255:0]       hash;
  logic [255:0]       hash_next;
  logic [255:0]       init_c;
  logic [255:0]       rnd_out;
`ifdef SHA224_EN
  logic               mode;
`endif

  // Schedule expansion: R new words appended, later ones may use earlier new ones.
  always_comb begin : p_sched
    logic [31:0] ext [0:19];
    for (int j = 0; j < 16; j++) ext[j] = win[j];
    for (int j = 16; j < 20; j++) ext[j] = 32'h0;
    for (int i = 0; i < R; i++) begin
      ext[16 + i] = ssig1(ext[14 + i]) + ext[9 + i] + ssig0(ext[1 + i]) + ext[i];
    end
    for (int j = 0; j < 16; j++) win_next[j] = ext[j + R];
  end

  // Chain of R rounds; stage i uses round index cnt+i and window word i.
  for (genvar i = 0; i < R; i++) begin : g_rnd
    logic [255:0] st_in;
    logic [255:0] st_out;
    logic [5:0]   kidx;
    if (i == 0) begin : g_head
      assign st_in = work;
    end else begin : g_link
      assign st_in = g_rnd[i-1].st_out;
    end
    assign kidx = cnt[5:0] + 6'(i);
    sha256_round u_round (
      .state_in  (st_in),
      .k         (K_TAB[kidx]),
      .w         (win[i]),
      .state_out (st_out)
    );
  end
  assign rnd_out = g_rnd[R-1].st_out;

  // Per-word feed-forward add of the block's chaining value and final a..h.
  always_comb begin
    hash_next = 256'h0;
    for (int j = 0; j < 8; j++) begin
      hash_next[32*j +: 32] = base[32*j +: 32] + work[32*j +: 32];
    end
  end

  // Chaining value for an accepted block: IV for a new message, else current H.
  always_comb begin
    init_c = hash;
    if (blk_first) begin
`ifdef SHA224_EN
      init_c = mode_224 ? IV_224 : IV_256;
`else
      init_c = IV_256;
`endif
    end else begin
      init_c = hash;
    end
  end

  // Controller FSM, datapath registers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= 7'd0;
      win          <= 512'h0;
      work         <= 256'h0;
      base         <= 256'h0;
      hash         <= 256'h0;
      digest       <= 256'h0;
      digest_valid <= 1'b0;
      blk_ready    <= 1'b1;
      busy         <= 1'b0;
`ifdef SHA224_EN
      mode         <= 1'b0;
`endif
    end else begin
      digest_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (blk_valid) begin
            for (int j = 0; j < 16; j++) win[j] <= blk_data[511 - 32*j -: 32];
            base      <= init_c;
            work      <= init_c;
            cnt       <= 7'd0;
            state     <= ST_ROUND;
            blk_ready <= 1'b0;
            busy      <= 1'b1;
`ifdef SHA224_EN
            if (blk_first) mode <= mode_224;
`endif
          end
        end
        ST_ROUND: begin
          work <= rnd_out;
          win  <= win_next;
          cnt  <= cnt + 7'(R);
          if (cnt == 7'(64 - R)) state <= ST_FINAL;
        end
        ST_FINAL: begin
          hash <= hash_next;
`ifdef SHA224_EN
          digest <= mode ? {hash_next[255:32], 32'h0} : hash_next;
`else
          digest <= hash_next;
`endif
          digest_valid <= 1'b1;
          state        <= ST_IDLE;
          blk_ready    <= 1'b1;
          busy         <= 1'b0;
        end
        default: begin
          state     <= ST_IDLE;
          blk_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_compress_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sha256_compress_ctrl
//   Directed bench for sha256_compress_ctrl. Three instances (1, 2 and 4
//   rounds per cycle) share clock and block data; each has its own reset and
//   valid so the same sequence runs on each in turn. Expected digests are the
//   published SHA-256 values of "abc" and the two-block 448-bit message.
// ---------------------------------------------------------------------------

module tb_sha256_compress_ctrl;

  localparam logic [511:0] BLK_ABC = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_M1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_M2 = {480'h0, 32'h000001c0};
  localparam logic [511:0] BLK_JUNK = {16{32'h5a5aa5a5}};

  localparam logic [255:0] DIG_ABC = {
    32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
    32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
  localparam logic [255:0] DIG_M = {
    32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039,
    32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1};
  localparam logic [255:0] DIG_224 = {
    32'h23097d22, 32'h3405d822, 32'h8642a477, 32'hbda255b3,
    32'h2aadbce4, 32'hbda0b3f7, 32'he36c9da7, 32'h00000000};

  logic         clk;
  logic [2:0]   rst;
  logic [2:0]   blk_valid;
  logic [2:0]   blk_ready;
  logic [2:0]   busy;
  logic [2:0]   digest_valid;
  logic [255:0] digest [3];
  logic [511:0] blk_data;
  logic         blk_first;
  logic         mode_224;

  int errors = 0;
  int checks = 0;

  sha256_compress_ctrl #(.ROUNDS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst(rst[0]), .blk_valid(blk_valid[0]), .blk_ready(blk_ready[0]),
    .blk_data(blk_data), .blk_first(blk_first),
`ifdef SHA224_EN
    .mode_224(mode_224),
`endif
    .busy(busy[0]), .digest(digest[0]), .digest_valid(digest_valid[0]));

  sha256_compress_ctrl #(.ROUNDS_PER_CYCLE(2)) u_dut2 (
    .clk(clk), .rst(rst[1]), .blk_valid(blk_valid[1]), .blk_ready(blk_ready[1]),
    .blk_data(blk_data), .blk_first(blk_first),
`ifdef SHA224_EN
    .mode_224(mode_224),
`endif
    .busy(busy[1]), .digest(digest[1]), .digest_valid(digest_valid[1]));

  sha256_compress_ctrl #(.ROUNDS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst(rst[2]), .blk_valid(blk_valid[2]), .blk_ready(blk_ready[2]),
    .blk_data(blk_data), .blk_first(blk_first),
`ifdef SHA224_EN
    .mode_224(mode_224),
`endif
    .busy(busy[2]), .digest(digest[2]), .digest_valid(digest_valid[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a block to instance d, wait for acceptance, then count edges to the pulse.
  task automatic run_block(input int d, input logic [511:0] data, input logic first,
                           output int edges);
    int n;
    blk_data     = data;
    blk_first    = first;
    blk_valid[d] = 1'b1;
    n = 0;
    while (!blk_ready[d] && n < 200) begin
      tick();
      n++;
    end
    tick();
    blk_valid[d] = 1'b0;
    edges = 0;
    while (!digest_valid[d] && edges < 300) begin
      tick();
      edges++;
    end
  endtask

  task automatic run_dut(input int d, input int rpc);
    int lat;
    int e;
    int n;
    logic ready_low_ok;
    logic saw_pulse;
    string s;
    lat = 64 / rpc + 1;
    s = $sformatf("r%0d_", rpc);

    // Reset state.
    rst[d] = 1'b1;
    tick();
    tick();
    rst[d] = 1'b0;
    check_val({s, "rst_ready"}, 256'(blk_ready[d]), 256'(1));
    check_val({s, "rst_busy"}, 256'(busy[d]), 256'(0));
    check_val({s, "rst_dv"}, 256'(digest_valid[d]), 256'(0));
    check_val({s, "rst_digest"}, digest[d], 256'h0);

    // Single "abc" block: latency and digest, pulse lasts one cycle.
    run_block(d, BLK_ABC, 1'b1, e);
    check_val({s, "abc_latency"}, 256'(e), 256'(lat));
    check_val({s, "abc_digest"}, digest[d], DIG_ABC);
    tick();
    check_val({s, "abc_pulse_end"}, 256'(digest_valid[d]), 256'(0));
    check_val({s, "abc_digest_hold"}, digest[d], DIG_ABC);

    // Two-block message, second block chains from H.
    run_block(d, BLK_M1, 1'b1, e);
    check_val({s, "m1_latency"}, 256'(e), 256'(lat));
    run_block(d, BLK_M2, 1'b0, e);
    check_val({s, "m2_digest"}, digest[d], DIG_M);
    tick();

    // Valid held high: data changed while busy must be ignored.
    blk_data     = BLK_ABC;
    blk_first    = 1'b1;
    blk_valid[d] = 1'b1;
    tick();
    blk_data  = BLK_JUNK;
    blk_first = 1'b0;
    check_val({s, "hold_busy"}, 256'(busy[d]), 256'(1));
    n = 0;
    ready_low_ok = 1'b1;
    while (!digest_valid[d] && n < 300) begin
      if (blk_ready[d]) ready_low_ok = 1'b0;
      tick();
      n++;
    end
    check_val({s, "hold_ready_low"}, 256'(ready_low_ok), 256'(1));
    check_val({s, "hold_latency1"}, 256'(n), 256'(lat));
    check_val({s, "hold_digest1"}, digest[d], DIG_ABC);
    blk_data  = BLK_ABC;
    blk_first = 1'b1;
    tick();
    blk_valid[d] = 1'b0;
    check_val({s, "hold_reaccept"}, 256'(busy[d]), 256'(1));
    check_val({s, "hold_single_pulse"}, 256'(digest_valid[d]), 256'(0));
    n = 0;
    while (!digest_valid[d] && n < 300) begin
      tick();
      n++;
    end
    check_val({s, "hold_latency2"}, 256'(n), 256'(lat));
    check_val({s, "hold_digest2"}, digest[d], DIG_ABC);
    tick();

    // Reset in mid-run abandons the block without a pulse.
    blk_data     = BLK_ABC;
    blk_first    = 1'b1;
    blk_valid[d] = 1'b1;
    tick();
    blk_valid[d] = 1'b0;
    repeat (30 / rpc) tick();
    rst[d] = 1'b1;
    tick();
    rst[d] = 1'b0;
    check_val({s, "abort_digest"}, digest[d], 256'h0);
    check_val({s, "abort_ready"}, 256'(blk_ready[d]), 256'(1));
    check_val({s, "abort_busy"}, 256'(busy[d]), 256'(0));
    saw_pulse = 1'b0;
    for (int i = 0; i < lat + 5; i++) begin
      if (digest_valid[d]) saw_pulse = 1'b1;
      tick();
    end
    check_val({s, "abort_no_pulse"}, 256'(saw_pulse), 256'(0));
    run_block(d, BLK_ABC, 1'b1, e);
    check_val({s, "rerun_latency"}, 256'(e), 256'(lat));
    check_val({s, "rerun_digest"}, digest[d], DIG_ABC);
    tick();

`ifdef SHA224_EN
    mode_224 = 1'b1;
    run_block(d, BLK_ABC, 1'b1, e);
    mode_224 = 1'b0;
    check_val({s, "sha224_digest"}, digest[d], DIG_224);
    tick();
`endif
  endtask

  initial begin
    rst       = 3'b111;
    blk_valid = 3'b000;
    blk_data  = 512'h0;
    blk_first = 1'b0;
    mode_224  = 1'b0;
    tick();
    tick();
    rst = 3'b000;

    run_dut(0, 1);
    run_dut(1, 2);
    run_dut(2, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
